// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Shares the single register-file write port between NUM_UNITS result
//   producers. Each producer owns a one-entry holding buffer with a
//   valid/ready handshake; a round-robin arbiter picks one full buffer per
//   cycle and drives a registered writeback beat. Results addressed to x0
//   are accepted and discarded. A pipeline flush empties every buffer.
//
// Optional feature macro: WB_STALL_CNT_EN
//   Defined   -> stall_cnt_o counts edges on which two or more buffers are
//                full (some unit is waiting). Cleared by reset only.
//   Undefined -> stall_cnt_o and its counter are absent.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid_i     per-unit result valid
//   req_adr_i       per-unit destination register, slice [5k+4:5k]
//   req_data_i      per-unit result, slice [xlen*k+xlen-1:xlen*k]
//   req_ready_o     per-unit buffer can accept this cycle (combinational)
//   flush           synchronous pipeline flush
//   res_v           register-file write strobe (registered)
//   res_adr         write address (registered)
//   res_data        write data (registered)
//   stall_cnt_o     contention counter (WB_STALL_CNT_EN only)
module writeback_arbiter #(
   parameter int xlen      = 32,
   parameter int NUM_UNITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_UNITS-1:0]      req_valid_i,
   input  logic [5*NUM_UNITS-1:0]    req_adr_i,
   input  logic [xlen*NUM_UNITS-1:0] req_data_i,
   output logic [NUM_UNITS-1:0]      req_ready_o,
   input  logic                      flush,
   output logic                      res_v,
   output logic [4:0]                res_adr,
   output logic [xlen-1:0]           res_data
`ifdef WB_STALL_CNT_EN
   ,
   output logic [31:0]               stall_cnt_o
`endif
);

   localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [NUM_UNITS-1:0] buf_v_r;
   logic [4:0]           buf_adr_r  [NUM_UNITS];
   logic [xlen-1:0]      buf_data_r [NUM_UNITS];
   logic [PW-1:0]        rr_ptr_r;

   logic [NUM_UNITS-1:0] grant_s;
   logic [PW-1:0]        gnt_idx_s;
   logic [PW-1:0]        ptr_next_s;
   logic [NUM_UNITS-1:0] accept_s;
   logic                 found_s;
   int                   idx_s;

   // Round-robin search: first full buffer starting at rr_ptr, wrapping.
   always_comb begin
      grant_s   = '0;
      gnt_idx_s = '0;
      found_s   = 1'b0;
      idx_s     = 0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         idx_s = (int'(rr_ptr_r) + i) % NUM_UNITS;
         if (!found_s && buf_v_r[idx_s]) begin
            found_s          = 1'b1;
            grant_s[idx_s]   = 1'b1;
            gnt_idx_s        = PW'(idx_s);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Pointer moves to the unit just after the winner.
   always_comb begin
      if (int'(gnt_idx_s) == NUM_UNITS - 1) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = gnt_idx_s + PW'(1);
      end
   end

   // A buffer being drained this edge can refill in the same edge.
   assign req_ready_o = ~buf_v_r | grant_s;
   assign accept_s    = req_valid_i & req_ready_o;

   // Holding buffers, round-robin pointer and the registered writeback beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_v_r  <= '0;
         rr_ptr_r <= '0;
         res_v    <= 1'b0;
         res_adr  <= 5'd0;
         res_data <= '0;
         for (int k = 0; k < NUM_UNITS; k++) begin
            buf_adr_r[k]  <= 5'd0;
            buf_data_r[k] <= '0;
         end
      end else if (flush) begin
         // Flush drops buffered results and in-flight requests; the
         // pointer is kept so fairness carries across the flush.
         buf_v_r <= '0;
         res_v   <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_UNITS; k++) begin
            if (accept_s[k]) begin
               // x0 results are consumed without occupying the buffer.
               buf_v_r[k]    <= (req_adr_i[5*k +: 5] != 5'd0);
               buf_adr_r[k]  <= req_adr_i[5*k +: 5];
               buf_data_r[k] <= req_data_i[xlen*k +: xlen];
            end else if (grant_s[k]) begin
               buf_v_r[k] <= 1'b0;
            end
         end
         res_v <= |grant_s;
         if (|grant_s) begin
            res_adr  <= buf_adr_r[gnt_idx_s];
            res_data <= buf_data_r[gnt_idx_s];
            rr_ptr_r <= ptr_next_s;
         end
      end
   end

`ifdef WB_STALL_CNT_EN
   function automatic int count_ones(input logic [NUM_UNITS-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

   // Contention counter: counts on flush edges too, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_o <= 32'd0;
      end else if (count_ones(buf_v_r) >= 2) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule
